seq_shift_rotate: RTL

//  Multi-cycle iterative shift/rotate unit for the WISC datapath; moves one bit per clock.

---
 rtl/seq_shift_rotate_pkg.sv | 10 +
 rtl/seq_shift_rotate_if.sv | 23 ++
 rtl/seq_shift_rotate_step.sv | 17 +
 rtl/seq_shift_rotate.sv | 62 ++++++
 4 files changed

// File: rtl/seq_shift_rotate_pkg.sv
// shift_pkg: shared types and default sizes for the iterative shift/rotate unit
package shift_pkg;

    localparam int SH_WIDTH = 16;
    localparam int SH_CNT_W = 4;

    typedef enum logic [1:0] {SH_SLL, SH_SRA, SH_ROR, SH_SRL} shift_mode_t;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} shift_state_t;

endpackage

// File: rtl/seq_shift_rotate_if.sv
// seq_shift_rotate_if: start/done handshake and operand/result bus of the shift unit
interface seq_shift_rotate_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] Shift_In;
    logic [CNT_W-1:0] Shift_Val;
    logic [1:0]       Mode;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Shift_Out;

    modport master (
        output start, Shift_In, Shift_Val, Mode,
        input  busy, done, Shift_Out
    );

    modport slave (
        input  start, Shift_In, Shift_Val, Mode,
        output busy, done, Shift_Out
    );
endinterface

// File: rtl/seq_shift_rotate_step.sv
// shift_step: combinational one-bit shift/rotate step selected by mode
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = SH_WIDTH
) (
    input  logic [WIDTH-1:0] i_data,
    input  shift_mode_t      i_mode,
    output logic [WIDTH-1:0] o_data
);

    assign o_data = (i_mode == SH_SLL) ? {i_data[WIDTH-2:0], 1'b0} :
                    (i_mode == SH_SRA) ? {i_data[WIDTH-1], i_data[WIDTH-1:1]} :
                    (i_mode == SH_ROR) ? {i_data[0], i_data[WIDTH-1:1]} :
                                         {1'b0, i_data[WIDTH-1:1]};

endmodule

// File: rtl/seq_shift_rotate.sv
// seq_shift_rotate: iterative shifter moving one bit per clock with start/done handshake
module seq_shift_rotate
    import shift_pkg::*;
#(
    parameter int WIDTH = SH_WIDTH,
    parameter int CNT_W = SH_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_shift_rotate_if.slave bus
);

    shift_state_t     r_state;
    shift_mode_t      r_mode;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_next;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .i_data (r_data),
        .i_mode (r_mode),
        .o_data (w_next)
    );

    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.Shift_Out = r_out;

    // capture operands in IDLE, step once per clock in SHIFT, publish result into DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mode  <= SH_SLL;
            r_data  <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_data  <= bus.Shift_In;
                        r_cnt   <= bus.Shift_Val;
                        r_mode  <= shift_mode_t'(bus.Mode);
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_data <= w_next;
                        r_cnt  <= r_cnt - CNT_W'(1);
                    end else begin
                        r_out   <= r_data;
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
